// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: requester handshake, flush, and the CDB broadcast.
// Handshake: a requester's result is accepted in the cycle where
// req_valid[i] && req_ready[i]. req_ready may depend on req_valid, but
// req_valid must never depend on req_ready. The accepted requester drives
// its result on req_data[i] in the cycle after that handshake.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    failure;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;

  // Execution units and flush source side
  modport master (
    output req_valid, req_tag, req_data, failure,
    input  req_ready, cdb_valid, cdb_tag, cdb_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_tag, req_data, failure,
    output req_ready, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: one grant per cycle, broadcast two
// cycles after the grant. Optional performance counters are built when the
// macro CDB_ARB_PERF_EN is defined. N_REQ/TAG_W/DATA_W must match the
// parameters of the connected cdb_arbiter_if instance.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  cdb_arbiter_if.slave      bus
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [N_REQ*32-1:0] perf_grant_cnt,
  output logic [31:0]         perf_conflict_cnt
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  ptr_next;
  logic              grant;
  logic [N_REQ-1:0]  ready_vec;

  logic              g_valid;
  logic [IDX_W-1:0]  g_idx;
  logic [TAG_W-1:0]  g_tag;

  logic [TAG_W-1:0]  tag_arr  [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  // Split the flat requester buses into per-requester fields
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign tag_arr[gi]  = bus.req_tag[gi*TAG_W +: TAG_W];
    assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  // Round-robin search starting at rr_ptr for the first valid requester
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (int'(rr_ptr) + k >= N_REQ) cand = IDX_W'(int'(rr_ptr) + k - N_REQ);
      else                            cand = IDX_W'(int'(rr_ptr) + k);
      if (!grant && bus.req_valid[cand]) begin
        grant  = 1'b1;
        winner = cand;
      end
    end
  end

  assign ptr_next = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);

  // One-hot ready; suppressed during flush and while reset is asserted so
  // no requester sees a handshake the arbiter will not honour
  always_comb begin
    ready_vec = '0;
    if (grant && !bus.failure && rst_n) ready_vec[winner] = 1'b1;
  end

  assign bus.req_ready = ready_vec;

  // Grant register and round-robin pointer; a flush kills the grant being made
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      g_valid <= 1'b0;
      g_idx   <= '0;
      g_tag   <= '0;
    end else begin
      g_valid <= grant && !bus.failure;
      g_idx   <= winner;
      g_tag   <= tag_arr[winner];
      if (grant) rr_ptr <= ptr_next;
    end
  end

  // Broadcast register; a flush also kills the grant made the cycle before,
  // while tag/data keep their last broadcast when nothing is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_data  <= '0;
    end else begin
      bus.cdb_valid <= g_valid && !bus.failure;
      if (g_valid) begin
        bus.cdb_tag  <= g_tag;
        bus.cdb_data <= data_arr[g_idx];
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [31:0] grant_cnt [N_REQ];
  logic [31:0] conflict_cnt;

  // Saturating per-requester grant counters; flushed grants are still counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant && (winner == IDX_W'(i)) && (grant_cnt[i] != 32'hFFFF_FFFF))
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
    end
  end

  // Saturating count of cycles with two or more requesters competing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (($countones(bus.req_valid) >= 2) && (conflict_cnt != 32'hFFFF_FFFF)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf_pack
    assign perf_grant_cnt[gi*32 +: 32] = grant_cnt[gi];
  end
  assign perf_conflict_cnt = conflict_cnt;
`endif

endmodule
